// File: rtl/genloop_pipe_subtractor.sv
// Pipelined ripple-borrow subtractor: {out[WIDTH], out[WIDTH-1:0]} = a - b - bin,
// resolving SEG bits per register stage, with valid/ready handshakes at both ends.
module genloop_pipe_subtractor #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned SEG   = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             bin,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH:0]   out
);

   localparam int unsigned NSTG = (WIDTH + SEG - 1) / SEG;

   logic [NSTG-1:0] v_vec;
   logic [NSTG:0]   rdy;

   // A stage may load when it is empty or its successor is loading this cycle.
   always_comb begin
      rdy       = '0;
      rdy[NSTG] = out_ready;
      for (int k = NSTG - 1; k >= 0; k--) begin
         rdy[k] = ~v_vec[k] | rdy[k+1];
      end
   end

   for (genvar k = 0; k < NSTG; k++) begin : g_stg
      localparam int Lo = k * SEG;
      localparam int Hi = ((k + 1) * SEG < WIDTH) ? (k + 1) * SEG - 1 : WIDTH - 1;

      logic             v_in;
      logic             br_in;
      logic [WIDTH-1:0] a_in;
      logic [WIDTH-1:0] b_in;
      logic [WIDTH-1:0] d_in;

      logic             v_q;
      logic             br_q;
      logic             br_d;
      logic [WIDTH-1:0] a_q;
      logic [WIDTH-1:0] b_q;
      logic [WIDTH-1:0] d_q;
      logic [WIDTH-1:0] d_d;

      if (k == 0) begin : g_head
         assign v_in  = in_valid;
         assign br_in = bin;
         assign a_in  = a;
         assign b_in  = b;
         assign d_in  = '0;
      end else begin : g_body
         assign v_in  = g_stg[k-1].v_q;
         assign br_in = g_stg[k-1].br_q;
         assign a_in  = g_stg[k-1].a_q;
         assign b_in  = g_stg[k-1].b_q;
         assign d_in  = g_stg[k-1].d_q;
      end

      always_comb begin : p_seg
         logic br;
         br  = br_in;
         d_d = d_in;
         for (int i = Lo; i <= Hi; i++) begin
            d_d[i] = a_in[i] ^ b_in[i] ^ br;
            br     = (~a_in[i] & b_in[i]) | (~(a_in[i] ^ b_in[i]) & br);
         end
         br_d = br;
      end

      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            v_q  <= 1'b0;
            br_q <= 1'b0;
            a_q  <= '0;
            b_q  <= '0;
            d_q  <= '0;
         end else if (rdy[k]) begin
            v_q  <= v_in;
            br_q <= br_d;
            a_q  <= a_in;
            b_q  <= b_in;
            d_q  <= d_d;
         end
      end

      assign v_vec[k] = v_q;
   end

   // The last stage has no consumer for its operand copies.
   logic unused_ops;
   assign unused_ops = ^{g_stg[NSTG-1].a_q, g_stg[NSTG-1].b_q};

   assign in_ready  = rdy[0];
   assign out_valid = g_stg[NSTG-1].v_q;
   assign out       = {g_stg[NSTG-1].br_q, g_stg[NSTG-1].d_q};

endmodule

// File: tb/tb_genloop_pipe_subtractor.sv
// Directed and randomized bench for genloop_pipe_subtractor: an 8/2 instance and a 7/3
// instance, each checked against an a-b-bin arithmetic model through a result queue.
module tb_genloop_pipe_subtractor;

   logic       clk = 1'b0;
   logic       rst;

   logic       iv8, ir8, bin8, ov8, or8;
   logic [7:0] a8, b8;
   logic [8:0] o8;

   logic       iv7, ir7, bin7, ov7, or7;
   logic [6:0] a7, b7;
   logic [7:0] o7;

   int nvec = 0;
   int nerr = 0;

   logic [8:0] q8[$];
   logic [7:0] q7[$];

   always #5 clk = ~clk;

   genloop_pipe_subtractor #(.WIDTH(8), .SEG(2)) u_dut8 (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (iv8),
      .in_ready  (ir8),
      .a         (a8),
      .b         (b8),
      .bin       (bin8),
      .out_valid (ov8),
      .out_ready (or8),
      .out       (o8)
   );

   genloop_pipe_subtractor #(.WIDTH(7), .SEG(3)) u_dut7 (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (iv7),
      .in_ready  (ir7),
      .a         (a7),
      .b         (b7),
      .bin       (bin7),
      .out_valid (ov7),
      .out_ready (or7),
      .out       (o7)
   );

   task automatic chk(input string tag, input logic [8:0] obs, input logic [8:0] exp);
      nvec++;
      assert (obs === exp) else begin
         nerr++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [8:0] ref8(input logic [7:0] x, input logic [7:0] y,
                                       input logic c);
      return {1'b0, x} - {1'b0, y} - 9'(c);
   endfunction

   function automatic logic [7:0] ref7(input logic [6:0] x, input logic [6:0] y,
                                       input logic c);
      return {1'b0, x} - {1'b0, y} - 8'(c);
   endfunction

   // Drive at the falling edge, observe just after, then advance one full cycle.
   task automatic step8(input logic iv, input logic [7:0] x, input logic [7:0] y,
                        input logic c, input logic ordy);
      iv8 = iv; a8 = x; b8 = y; bin8 = c; or8 = ordy;
      #1;
      if (ov8 && or8) begin
         if (q8.size() == 0) chk("sb8_unexpected", {8'b0, ov8}, 9'h000);
         else                chk("sb8_data", o8, q8.pop_front());
      end
      if (iv8 && ir8) q8.push_back(ref8(x, y, c));
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic step7(input logic iv, input logic [6:0] x, input logic [6:0] y,
                        input logic c, input logic ordy);
      iv7 = iv; a7 = x; b7 = y; bin7 = c; or7 = ordy;
      #1;
      if (ov7 && or7) begin
         if (q7.size() == 0) chk("sb7_unexpected", {8'b0, ov7}, 9'h000);
         else                chk("sb7_data", {1'b0, o7}, {1'b0, q7.pop_front()});
      end
      if (iv7 && ir7) q7.push_back(ref7(x, y, c));
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic directed8(input logic [7:0] x, input logic [7:0] y, input logic c,
                            input logic [8:0] expv);
      int lat;
      step8(1'b1, x, y, c, 1'b1);
      lat = 1;
      while (!ov8 && lat < 12) begin
         step8(1'b0, 8'h00, 8'h00, 1'b0, 1'b1);
         lat++;
      end
      chk("lat8", 9'(lat), 9'd4);
      chk("dir8", o8, expv);
      step8(1'b0, 8'h00, 8'h00, 1'b0, 1'b1);
   endtask

   task automatic drain8();
      int n = 0;
      while (q8.size() != 0 && n < 40) begin
         step8(1'b0, 8'h00, 8'h00, 1'b0, 1'b1);
         n++;
      end
      chk("drain8", 9'(q8.size()), 9'd0);
   endtask

   task automatic drain7();
      int n = 0;
      while (q7.size() != 0 && n < 40) begin
         step7(1'b0, 7'h00, 7'h00, 1'b0, 1'b1);
         n++;
      end
      chk("drain7", 9'(q7.size()), 9'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: observed timeout expected completion");
      $fatal(1, "bench timed out");
   end

   initial begin
      logic [8:0] held;
      int         lat;
      rst = 1'b1;
      iv8 = 1'b0; a8 = '0; b8 = '0; bin8 = 1'b0; or8 = 1'b1;
      iv7 = 1'b0; a7 = '0; b7 = '0; bin7 = 1'b0; or7 = 1'b1;
      repeat (2) @(negedge clk);
      chk("rst_ov", {8'b0, ov8}, 9'h000);
      chk("rst_out", o8, 9'h000);
      chk("rst_ir", {8'b0, ir8}, 9'h001);
      chk("rst_ov7", {8'b0, ov7}, 9'h000);
      rst = 1'b0;

      directed8(8'h05, 8'h03, 1'b0, 9'h002);
      directed8(8'h00, 8'h01, 1'b0, 9'h1FF);
      directed8(8'hFF, 8'hFF, 1'b1, 9'h1FF);

      // Back-to-back stream.
      for (int i = 0; i < 8; i++) begin
         step8(1'b1, 8'($urandom), 8'($urandom), 1'($urandom_range(0, 1)), 1'b1);
         chk("ir_b2b", {8'b0, ir8}, 9'h001);
      end
      drain8();

      // Fill against a stalled consumer.
      for (int i = 0; i < 6; i++) begin
         step8(1'b1, 8'($urandom), 8'($urandom), 1'($urandom_range(0, 1)), 1'b0);
         chk("ir_stall", {8'b0, ir8}, {8'b0, (i < 3)});
      end
      chk("full_cnt", 9'(q8.size()), 9'd4);
      held = o8;
      step8(1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
      chk("hold_out", o8, held);
      chk("hold_ov", {8'b0, ov8}, 9'h001);
      or8 = 1'b1; iv8 = 1'b1;
      #1;
      chk("ir_full_pass", {8'b0, ir8}, 9'h001);
      step8(1'b1, 8'h9C, 8'h3A, 1'b1, 1'b1);
      chk("full_swap_cnt", 9'(q8.size()), 9'd4);
      drain8();

      // Asynchronous reset with results in flight.
      for (int i = 0; i < 3; i++) begin
         step8(1'b1, 8'($urandom), 8'($urandom), 1'b0, 1'b1);
      end
      rst = 1'b1;
      #1;
      chk("arst_ov", {8'b0, ov8}, 9'h000);
      chk("arst_out", o8, 9'h000);
      chk("arst_ir", {8'b0, ir8}, 9'h001);
      q8.delete();
      @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < 8; i++) begin
         step8(1'b0, 8'h00, 8'h00, 1'b0, 1'b1);
         chk("no_stale", {8'b0, ov8}, 9'h000);
      end

      for (int i = 0; i < 300; i++) begin
         step8(1'($urandom_range(0, 1)), 8'($urandom), 8'($urandom),
               1'($urandom_range(0, 1)), ($urandom_range(0, 3) != 0));
      end
      drain8();

      // Narrow instance with a partial last segment.
      step7(1'b1, 7'h40, 7'h41, 1'b0, 1'b1);
      lat = 1;
      while (!ov7 && lat < 12) begin
         step7(1'b0, 7'h00, 7'h00, 1'b0, 1'b1);
         lat++;
      end
      chk("lat7", 9'(lat), 9'd3);
      chk("dir7", {1'b0, o7}, 9'h0FF);
      step7(1'b0, 7'h00, 7'h00, 1'b0, 1'b1);
      for (int i = 0; i < 200; i++) begin
         step7(1'($urandom_range(0, 1)), 7'($urandom), 7'($urandom),
               1'($urandom_range(0, 1)), ($urandom_range(0, 3) != 0));
      end
      drain7();

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
